vcfg_issue_ctrl: RTL and testbench
==================================

Name: vcfg_issue_ctrl

Overview:
Vector configuration and issue sequencer between the instruction decoder and the vector datapath (ALU / load-store).
- Owns the architectural vl/vtype state and executes vsetvli, vsetivli and vsetvl.
- Splits every other vector instruction into datapath beats of DATA_WIDTH bits, with a valid/ready handshake on each side.

Parameters:
VLEN, 128, bits per vector register
DATA_WIDTH, 64, datapath bits per beat (≥64)
XLEN, 32, scalar register width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  decoded instruction valid
in_ready  output  1  controller can accept an instruction
in_opcode_mjr  input  7  major opcode (OP-V 1010111, LOAD-FP 0000111, STORE-FP 0100111)
in_opcode_mnr  input  3  minor opcode; 3'b111 on OP-V = config
in_dest  input  5  rd / vd / vs3
in_src_1  input  5  rs1 / vs1 / uimm
in_cfg_type  input  2  insn[31:30]
in_zimm_11  input  11  vsetvli vtype immediate
in_zimm_10  input  10  vsetivli vtype immediate
rs1_data  input  XLEN  scalar rs1 value
rs2_data  input  XLEN  scalar rs2 value (vsetvl vtype)
rd_we  output  1  scalar writeback strobe
rd_addr  output  5  writeback register
rd_wdata  output  XLEN  new vl
out_valid  output  1  beat valid to datapath
out_ready  input  1  datapath accepts beat
out_opcode_mjr  output  7  captured major opcode
out_dest  output  5  captured dest
out_beat_idx  output  8  beat index from 0
out_elem_cnt  output  8  active elements this beat
out_last  output  1  final beat of instruction
vl_out  output  XLEN  current vl
vsew_out  output  3  current vsew
vlmul_out  output  3  current vlmul
vill_out  output  1  vtype illegal

Behaviour:
- Reset values: FSM=IDLE; vl=0; vsew=0; vlmul=0; vill=1; rd_we=0; out_valid=0; out_last=0; out_beat_idx=0; out_elem_cnt=0; in_ready=1 on the first cycle after reset.
- Reset asserted mid-operation aborts at the next edge: out_valid=0 the following cycle, no further beats.
- FSM states: IDLE, CFG, ISSUE.
- in_ready=1 only in IDLE. An instruction is accepted on in_valid&&in_ready; all input fields and rs data are captured at that edge.
- Acceptance in IDLE:
  - OP-V with mnr=7 → CFG.
  - OP-V / LOAD-FP / STORE-FP, vill=0, vl≠0 → ISSUE.
  - Vector instruction with vill=1 or vl=0 → accepted, retired, FSM stays IDLE, no beats.
  - Any other opcode → accepted and dropped.
- Config decode:
  - cfg_type[1]=0: vsetvli, vtype=zimm_11.
  - cfg_type=11: vsetivli, vtype=zimm_10, AVL=uimm(src_1).
  - cfg_type=10: vsetvl, vtype=rs2_data.
- vtype fields: vlmul=[2:0], vsew=[5:3].
- vill=1 when any of the following holds:
  - vlmul≥4 (fractional LMUL unsupported);
  - vsew>3;
  - 8<<vsew > DATA_WIDTH;
  - vtype bits above [7] are nonzero.
- VLMAX = (VLEN << vlmul) >> (3+vsew).
- AVL for vsetvli/vsetvl:
  - rs1≠x0 → rs1_data.
  - rs1=x0, rd≠x0 → VLMAX.
  - rs1=x0, rd=x0 → current vl.
- vl = min(AVL, VLMAX). If vill, then vl=0 and vsew/vlmul are cleared.
- CFG is 1 cycle: rd_we=1, rd_addr=dest, rd_wdata=new vl. vl/vtype registers update at the end of CFG. rd_we is suppressed when rd=x0. FSM → IDLE.
- Config latency: accept at cycle T → rd_we at T+1 → in_ready at T+2.
- ISSUE:
  - EPB (elements per beat) = DATA_WIDTH>>(3+vsew).
  - Beats = ceil(vl/EPB).
  - out_valid rises the cycle after acceptance.
  - A beat advances only on out_valid&&out_ready. Outputs are held stable while out_ready=0.
  - out_elem_cnt = min(EPB, vl − beat_idx·EPB).
  - out_last=1 on the final beat. The handshake of the last beat → IDLE, with out_valid=0 the next cycle.
- vl/vtype changes cannot occur during ISSUE, because acceptance is blocked.

Test Plan:
1. Reset, then vsetvli rs1=x5 (rs1_data=100), rd=x6, zimm e32 m2 → rd_we at T+1, rd_addr=6, rd_wdata=8; vl_out=8, vsew_out=2, vlmul_out=1, vill_out=0.
2. After test 1, OP-V vadd with out_ready=1 → 4 beats, elem_cnt 2,2,2,2, beat_idx 0..3, out_last only on beat 3, in_ready returns the cycle after beat 3.
3. vsetivli uimm=5, e16 m1 → vl=5; then LOAD-FP → 2 beats, elem_cnt 4,1; hold out_ready=0 for 3 cycles on beat 0 → outputs unchanged, no skipped beat.
4. vsetvl rs2_data=0x4 (vlmul=4) → vill_out=1, rd_wdata=0, vl_out=0; following vadd accepted with no out_valid; then vsetvli rs1=x0, rd=x0 → vl stays 0, rd_we=0.
5. vsetvli rs1=x0, rd=x1, e8 m8 → vl=128, rd_wdata=128; vadd → 16 beats of 8 elements.
6. rst asserted during beat 2 of a 4-beat issue → out_valid=0 next cycle, vl=0, vill=1, in_ready=1.

Source files
------------

// File: rtl/vcfg_issue_ctrl.sv
// Vector configuration / issue sequencer: owns vl and vtype, executes the vset* family,
// and splits every other vector instruction into DATA_WIDTH-bit datapath beats.
module vcfg_issue_ctrl #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode_mjr,
  input  logic [2:0]      in_opcode_mnr,
  input  logic [4:0]      in_dest,
  input  logic [4:0]      in_src_1,
  input  logic [1:0]      in_cfg_type,
  input  logic [10:0]     in_zimm_11,
  input  logic [9:0]      in_zimm_10,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode_mjr,
  output logic [4:0]      out_dest,
  output logic [7:0]      out_beat_idx,
  output logic [7:0]      out_elem_cnt,
  output logic            out_last,
  output logic [XLEN-1:0] vl_out,
  output logic [2:0]      vsew_out,
  output logic [2:0]      vlmul_out,
  output logic            vill_out
);

  localparam logic [6:0] OP_V     = 7'b1010111;
  localparam logic [6:0] LOAD_FP  = 7'b0000111;
  localparam logic [6:0] STORE_FP = 7'b0100111;

  typedef enum logic [1:0] {IDLE, CFG, ISSUE} state_e;

  state_e          state_q;
  logic            in_ready_q, rd_we_q, out_valid_q, out_last_q, vill_q, pend_vill_q;
  logic [4:0]      rd_addr_q, out_dest_q;
  logic [6:0]      out_opcode_q;
  logic [7:0]      beat_idx_q, elem_cnt_q;
  logic [2:0]      vsew_q, vlmul_q, pend_vsew_q, pend_vlmul_q;
  logic [XLEN-1:0] vl_q, rd_wdata_q, rem_q;

  logic            is_cfg_c, is_vec_c, new_vill_c;
  logic [2:0]      new_vsew_c, new_vlmul_c;
  logic [XLEN-1:0] vtype_c, avl_c, vlmax_c, new_vl_c, epb_c, rem_next_c;

  function automatic logic [XLEN-1:0] umin(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign is_cfg_c   = (in_opcode_mjr == OP_V) && (in_opcode_mnr == 3'b111);
  assign is_vec_c   = ((in_opcode_mjr == OP_V) && (in_opcode_mnr != 3'b111)) ||
                      (in_opcode_mjr == LOAD_FP) || (in_opcode_mjr == STORE_FP);
  assign epb_c      = XLEN'(DATA_WIDTH >> (32'd3 + 32'(vsew_q)));
  assign rem_next_c = rem_q - epb_c;

  // Decode the vset* form presented at the input and compute the resulting vl/vtype.
  always_comb begin
    vtype_c = XLEN'(in_zimm_11);
    avl_c   = rs1_data;
    if (in_cfg_type == 2'b11) begin
      vtype_c = XLEN'(in_zimm_10);
      avl_c   = XLEN'(in_src_1);
    end else if (in_cfg_type == 2'b10) begin
      vtype_c = rs2_data;
    end
    new_vlmul_c = vtype_c[2:0];
    new_vsew_c  = vtype_c[5:3];
    new_vill_c  = new_vlmul_c[2] || new_vsew_c[2] ||
                  ((32'd8 << new_vsew_c) > DATA_WIDTH) || (|vtype_c[XLEN-1:8]);
    vlmax_c     = XLEN'((VLEN << new_vlmul_c) >> (32'd3 + 32'(new_vsew_c)));
    if ((in_cfg_type != 2'b11) && (in_src_1 == 5'd0)) begin
      avl_c = (in_dest != 5'd0) ? vlmax_c : vl_q;
    end
    new_vl_c = umin(avl_c, vlmax_c);
    if (new_vill_c) begin
      new_vl_c    = '0;
      new_vsew_c  = '0;
      new_vlmul_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      rd_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_wdata_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_opcode_q <= '0;
      out_dest_q   <= '0;
      beat_idx_q   <= '0;
      elem_cnt_q   <= '0;
      rem_q        <= '0;
      vl_q         <= '0;
      vsew_q       <= '0;
      vlmul_q      <= '0;
      vill_q       <= 1'b1;
      pend_vsew_q  <= '0;
      pend_vlmul_q <= '0;
      pend_vill_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && is_cfg_c) begin
            state_q      <= CFG;
            in_ready_q   <= 1'b0;
            rd_we_q      <= (in_dest != 5'd0);
            rd_addr_q    <= in_dest;
            rd_wdata_q   <= new_vl_c;
            pend_vsew_q  <= new_vsew_c;
            pend_vlmul_q <= new_vlmul_c;
            pend_vill_q  <= new_vill_c;
          end else if (in_valid && is_vec_c && !vill_q && (vl_q != '0)) begin
            state_q      <= ISSUE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b1;
            out_opcode_q <= in_opcode_mjr;
            out_dest_q   <= in_dest;
            beat_idx_q   <= '0;
            elem_cnt_q   <= 8'(umin(epb_c, vl_q));
            out_last_q   <= (vl_q <= epb_c);
            rem_q        <= vl_q;
          end
        end
        // rd_wdata already holds the new vl, so commit straight from it.
        CFG: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          rd_we_q    <= 1'b0;
          vl_q       <= rd_wdata_q;
          vsew_q     <= pend_vsew_q;
          vlmul_q    <= pend_vlmul_q;
          vill_q     <= pend_vill_q;
        end
        ISSUE: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rem_q      <= rem_next_c;
              beat_idx_q <= beat_idx_q + 8'd1;
              elem_cnt_q <= 8'(umin(epb_c, rem_next_c));
              out_last_q <= (rem_next_c <= epb_c);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign rd_we          = rd_we_q;
  assign rd_addr        = rd_addr_q;
  assign rd_wdata       = rd_wdata_q;
  assign out_valid      = out_valid_q;
  assign out_opcode_mjr = out_opcode_q;
  assign out_dest       = out_dest_q;
  assign out_beat_idx   = beat_idx_q;
  assign out_elem_cnt   = elem_cnt_q;
  assign out_last       = out_last_q;
  assign vl_out         = vl_q;
  assign vsew_out       = vsew_q;
  assign vlmul_out      = vlmul_q;
  assign vill_out       = vill_q;

endmodule

// File: tb/tb_vcfg_issue_ctrl.sv
// Self-checking bench for vcfg_issue_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of vl/vtype and the expected beat/writeback streams.
module tb_vcfg_issue_ctrl;

  localparam int unsigned VLEN = 128;
  localparam int unsigned DW   = 64;
  localparam int unsigned XLEN = 32;
  localparam logic [6:0] OPV  = 7'b1010111;
  localparam logic [6:0] LDFP = 7'b0000111;
  localparam logic [6:0] STFP = 7'b0100111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      in_opcode_mjr = '0;
  logic [2:0]      in_opcode_mnr = '0;
  logic [4:0]      in_dest = '0;
  logic [4:0]      in_src_1 = '0;
  logic [1:0]      in_cfg_type = '0;
  logic [10:0]     in_zimm_11 = '0;
  logic [9:0]      in_zimm_10 = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [6:0]      out_opcode_mjr;
  logic [4:0]      out_dest;
  logic [7:0]      out_beat_idx;
  logic [7:0]      out_elem_cnt;
  logic            out_last;
  logic [XLEN-1:0] vl_out;
  logic [2:0]      vsew_out;
  logic [2:0]      vlmul_out;
  logic            vill_out;

  vcfg_issue_ctrl #(.VLEN(VLEN), .DATA_WIDTH(DW), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode_mjr(in_opcode_mjr), .in_opcode_mnr(in_opcode_mnr), .in_dest(in_dest),
    .in_src_1(in_src_1), .in_cfg_type(in_cfg_type), .in_zimm_11(in_zimm_11),
    .in_zimm_10(in_zimm_10), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode_mjr(out_opcode_mjr),
    .out_dest(out_dest), .out_beat_idx(out_beat_idx), .out_elem_cnt(out_elem_cnt),
    .out_last(out_last), .vl_out(vl_out), .vsew_out(vsew_out), .vlmul_out(vlmul_out),
    .vill_out(vill_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  mnr;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [1:0]  cfg;
    logic [10:0] z11;
    logic [9:0]  z10;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } ins_t;

  typedef struct {
    longint     idx;
    longint     cnt;
    bit         last;
    logic [6:0] op;
    logic [4:0] dest;
  } beat_t;

  beat_t  exp_q[$];
  longint wb_addr_q[$];
  longint wb_data_q[$];
  longint m_vl;
  longint m_sew;
  longint m_lmul;
  bit     m_vill;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     rdy_rand = 1'b0;
  bit     rdy_force = 1'b1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_vl = 0; m_sew = 0; m_lmul = 0; m_vill = 1'b1;
    exp_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
  endfunction

  // Architectural effect of one accepted instruction: vl = min(AVL, LMUL*VLEN/SEW).
  function automatic void model_accept(input ins_t i);
    longint vtype, avl, vlmax, sew, lmul, epb;
    bit ill;
    beat_t t;
    if (i.op == OPV && i.mnr == 3'd7) begin
      if (!i.cfg[1])           vtype = longint'(i.z11);
      else if (i.cfg == 2'b11) vtype = longint'(i.z10);
      else                     vtype = longint'(i.rs2d);
      lmul  = vtype % 64'd8;
      sew   = (vtype / 64'd8) % 64'd8;
      ill   = (lmul >= 4) || (sew > 3) || ((64'd8 << sew) > longint'(DW)) || (vtype >= 256);
      vlmax = ill ? 64'd0 : (longint'(VLEN) * (64'd1 << lmul)) / (64'd8 << sew);
      if (i.cfg == 2'b11)        avl = longint'(i.src1);
      else if (i.src1 != 5'd0)   avl = longint'(i.rs1d);
      else if (i.dest != 5'd0)   avl = vlmax;
      else                       avl = m_vl;
      m_vill = ill;
      m_vl   = ill ? 64'd0 : ((avl < vlmax) ? avl : vlmax);
      m_sew  = ill ? 64'd0 : sew;
      m_lmul = ill ? 64'd0 : lmul;
      if (i.dest != 5'd0) begin
        wb_addr_q.push_back(longint'(i.dest));
        wb_data_q.push_back(m_vl);
      end
    end else if (i.op == OPV || i.op == LDFP || i.op == STFP) begin
      if (!m_vill && m_vl != 0) begin
        epb = longint'(DW) / (64'd8 << m_sew);
        for (longint b = 0; b * epb < m_vl; b++) begin
          t.idx  = b;
          t.cnt  = (m_vl - b * epb < epb) ? (m_vl - b * epb) : epb;
          t.last = ((b + 1) * epb >= m_vl);
          t.op   = i.op;
          t.dest = i.dest;
          exp_q.push_back(t);
        end
      end
    end
  endfunction

  function automatic ins_t mk(input logic [6:0] op, input logic [2:0] mnr, input logic [4:0] dest,
                              input logic [4:0] src1, input logic [1:0] cfg, input logic [10:0] z11,
                              input logic [9:0] z10, input logic [31:0] rs1d, input logic [31:0] rs2d);
    ins_t i;
    i.op = op; i.mnr = mnr; i.dest = dest; i.src1 = src1; i.cfg = cfg;
    i.z11 = z11; i.z10 = z10; i.rs1d = rs1d; i.rs2d = rs2d;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int   kind = $urandom_range(0, 99);
    logic [31:0] vt;
    vt = ($urandom_range(0, 4) != 0) ?
         {24'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))} : $urandom;
    i = mk(OPV, 3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 2'($urandom), 11'(vt), 10'(vt),
           ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 300)) : $urandom, vt);
    if ($urandom_range(0, 3) == 0) i.dest = 5'd0;
    if ($urandom_range(0, 3) == 0) i.src1 = 5'd0;
    if (kind < 40) begin
      i.mnr = 3'd7;
    end else if (kind < 85) begin
      case ($urandom_range(0, 2))
        0:       i.op = OPV;
        1:       begin i.op = LDFP; i.mnr = 3'($urandom); end
        default: begin i.op = STFP; i.mnr = 3'($urandom); end
      endcase
    end else begin
      i.op = 7'($urandom);
      if (i.op == OPV || i.op == LDFP || i.op == STFP) i.op = 7'b0110011;
    end
    return i;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Compare process: beats, writebacks and architectural state against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", longint'(out_valid), 0);
        end else begin
          chk("beat_idx", longint'(out_beat_idx), exp_q[0].idx);
          chk("elem_cnt", longint'(out_elem_cnt), exp_q[0].cnt);
          chk("out_last", longint'(out_last), longint'(exp_q[0].last));
          chk("out_opcode", longint'(out_opcode_mjr), longint'(exp_q[0].op));
          chk("out_dest", longint'(out_dest), longint'(exp_q[0].dest));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (rd_we) begin
        if (wb_addr_q.size() == 0) begin
          chk("unexpected_rd_we", longint'(rd_we), 0);
        end else begin
          chk("rd_addr", longint'(rd_addr), wb_addr_q.pop_front());
          chk("rd_wdata", longint'(rd_wdata), wb_data_q.pop_front());
        end
      end
      if (in_ready) begin
        chk("vl_out", longint'(vl_out), m_vl);
        chk("vsew_out", longint'(vsew_out), m_sew);
        chk("vlmul_out", longint'(vlmul_out), m_lmul);
        chk("vill_out", longint'(vill_out), longint'(m_vill));
      end
    end
  end

  task automatic send(input ins_t i);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", longint'(in_ready), 1);
    end else begin
      in_valid = 1'b1; in_opcode_mjr = i.op; in_opcode_mnr = i.mnr; in_dest = i.dest;
      in_src_1 = i.src1; in_cfg_type = i.cfg; in_zimm_11 = i.z11; in_zimm_10 = i.z10;
      rs1_data = i.rs1d; rs2_data = i.rs2d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_accept(i);
    end
  endtask

  // Literal checks of the writeback cycle and the committed state one cycle later.
  task automatic cfg_check(input string tag, input longint we, input longint wdata, input longint vl,
                           input longint sew, input longint lmul, input longint vill);
    @(negedge clk);
    chk({tag, "_rd_we"}, longint'(rd_we), we);
    if (we != 0) chk({tag, "_rd_wdata"}, longint'(rd_wdata), wdata);
    chk({tag, "_busy"}, longint'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_ready"}, longint'(in_ready), 1);
    chk({tag, "_vl"}, longint'(vl_out), vl);
    chk({tag, "_vsew"}, longint'(vsew_out), sew);
    chk({tag, "_vlmul"}, longint'(vlmul_out), lmul);
    chk({tag, "_vill"}, longint'(vill_out), vill);
  endtask

  task automatic count_beats(input string tag, input longint exp_n, input longint exp_cnt);
    longint beats = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({tag, "_idx"}, longint'(out_beat_idx), beats);
        chk({tag, "_cnt"}, longint'(out_elem_cnt), exp_cnt);
        chk({tag, "_last"}, longint'(out_last), longint'(beats == exp_n - 1));
        beats++;
      end else if (beats > 0) begin
        break;
      end
    end
    chk({tag, "_beats"}, beats, exp_n);
    chk({tag, "_ready_after"}, longint'(in_ready), 1);
  endtask

  initial begin
    int n;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_rd_we", longint'(rd_we), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_beat_idx", longint'(out_beat_idx), 0);
    chk("rst_elem_cnt", longint'(out_elem_cnt), 0);
    chk("rst_vill", longint'(vill_out), 1);

    // vsetvli x6, x5(=100), e32 m2
    send(mk(OPV, 3'd7, 5'd6, 5'd5, 2'b00, 11'h011, 10'd0, 32'd100, 32'd0));
    cfg_check("t1", 1, 8, 8, 2, 1, 0);
    rdy_force = 1'b1;
    send(mk(OPV, 3'd0, 5'd2, 5'd3, 2'b00, 11'd0, 10'd0, 32'd0, 32'd0));
    count_beats("t2", 4, 2);

    // vsetivli uimm=5, e16 m1, then LOAD-FP with back-pressure on beat 0
    send(mk(OPV, 3'd7, 5'd7, 5'd5, 2'b11, 11'd0, 10'h008, 32'd0, 32'd0));
    cfg_check("t3cfg", 1, 5, 5, 1, 0, 0);
    rdy_force = 1'b0;
    send(mk(LDFP, 3'd0, 5'd9, 5'd1, 2'b00, 11'd0, 10'd0, 32'd0, 32'd0));
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_valid", longint'(out_valid), 1);
      chk("t3_hold_idx", longint'(out_beat_idx), 0);
      chk("t3_hold_cnt", longint'(out_elem_cnt), 4);
    end
    rdy_force = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_beat_idx == 8'd1) && n < 20);
    chk("t3_b1_cnt", longint'(out_elem_cnt), 1);
    chk("t3_b1_last", longint'(out_last), 1);

    // vsetvl with vlmul=4 -> vill, then a vector op that must retire silently
    send(mk(OPV, 3'd7, 5'd8, 5'd3, 2'b10, 11'd0, 10'd0, 32'd10, 32'h4));
    cfg_check("t4cfg", 1, 0, 0, 0, 0, 1);
    send(mk(OPV, 3'd0, 5'd2, 5'd3, 2'b00, 11'd0, 10'd0, 32'd0, 32'd0));
    @(negedge clk);
    chk("t4_no_beat", longint'(out_valid), 0);
    chk("t4_ready", longint'(in_ready), 1);
    send(mk(OPV, 3'd7, 5'd0, 5'd0, 2'b00, 11'h011, 10'd0, 32'd77, 32'd0));
    cfg_check("t4keep", 0, 0, 0, 2, 1, 0);

    // vsetvli x1, x0, e8 m8 -> VLMAX=128, 16 beats of 8
    send(mk(OPV, 3'd7, 5'd1, 5'd0, 2'b00, 11'h003, 10'd0, 32'd0, 32'd0));
    cfg_check("t5cfg", 1, 128, 128, 0, 3, 0);
    send(mk(STFP, 3'd2, 5'd4, 5'd0, 2'b00, 11'd0, 10'd0, 32'd0, 32'd0));
    count_beats("t5", 16, 8);

    // Reset during beat 2 of a 4-beat issue
    send(mk(OPV, 3'd7, 5'd6, 5'd5, 2'b00, 11'h011, 10'd0, 32'd100, 32'd0));
    cfg_check("t6cfg", 1, 8, 8, 2, 1, 0);
    send(mk(OPV, 3'd0, 5'd2, 5'd3, 2'b00, 11'd0, 10'd0, 32'd0, 32'd0));
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_beat_idx == 8'd2) && n < 20);
    chk("t6_reach_beat2", longint'(out_beat_idx), 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    @(negedge clk);
    chk("t6_out_valid", longint'(out_valid), 0);
    chk("t6_vl", longint'(vl_out), 0);
    chk("t6_vill", longint'(vill_out), 1);
    chk("t6_in_ready", longint'(in_ready), 1);

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 250; k++) begin
      send(rnd_ins());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_ready && exp_q.size() == 0) && n < 2000);
    chk("drain_beats", longint'(exp_q.size()), 0);
    chk("drain_wb", longint'(wb_addr_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
